commit_stream_checker: RTL and testbench

//  Parametrised, synthesisable retirement checker that sits beside the ROB commit port.
//  - Accepts up to COMMIT_WIDTH retirements per cycle and compacts them into an in-order queue.
//  - Drains one entry per cycle against a golden expected-retirement stream (valid/ready).
//  - Compares PC, rd and writeback data; keeps error/commit counters and first-error capture.
//  - Runs a halt-drain-done state machine.

---
 rtl/commit_stream_checker_pkg.sv | 20 ++
 rtl/commit_stream_checker_fifo.sv | 46 ++++
 rtl/commit_stream_checker.sv | 86 ++++++++
 tb/tb_commit_stream_checker.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_stream_checker_pkg.sv
// commit_stream_checker_pkg: shared types and helpers for the retirement checker.
// Entry field widths follow CHK_XLEN; the checker's XLEN must match it.
package commit_stream_checker_pkg;
    localparam int CHK_XLEN = 32;

    typedef struct packed {
        logic [CHK_XLEN-1:0] pc;
        logic [4:0]          rd;
        logic [CHK_XLEN-1:0] data;
    } commit_entry_t;

    typedef enum logic [1:0] {CHK_RUN, CHK_DRAIN, CHK_DONE, CHK_ERR} chk_state_t;

    // Number of set bits in v below bit position i: the queue slot of lane i.
    function automatic int ones_below(input logic [7:0] v, input int i);
        ones_below = 0;
        for (int j = 0; j < 8; j++)
            if (j < i && v[j]) ones_below++;
    endfunction
endpackage

// File: rtl/commit_stream_checker_fifo.sv
// commit_fifo: multi-push, single-pop circular queue of commit entries.
// push_mask is contiguous from slot 0; slot k lands at wr_ptr+k.
module commit_fifo
    import commit_stream_checker_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int DEPTH        = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic          [COMMIT_WIDTH-1:0]    push_mask,
    input  commit_entry_t [COMMIT_WIDTH-1:0]    push_entry,
    input  logic                                pop,
    output logic          [$clog2(DEPTH):0]     count,
    output commit_entry_t                       head
);
    localparam int AW = $clog2(DEPTH);

    commit_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   n_push;

    always_comb begin
        n_push = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++)
            n_push = n_push + (AW+1)'(push_mask[k]);
    end

    always_ff @(posedge clk)
        for (int k = 0; k < COMMIT_WIDTH; k++)
            if (push_mask[k]) mem[wr_ptr + AW'(k)] <= push_entry[k];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + n_push - (AW+1)'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/commit_stream_checker.sv
// commit_stream_checker: compacts ROB retirements, checks them against a golden stream.
// COMMIT_CHK_STOP_ON_ERR_EN: first mismatch parks the checker in CHK_ERR.
module commit_stream_checker
    import commit_stream_checker_pkg::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int DEPTH        = 16,
    parameter int XLEN         = CHK_XLEN,
    parameter int CNT_W        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COMMIT_WIDTH-1:0]    cmt_valid,
    input  logic [COMMIT_WIDTH*XLEN-1:0] cmt_pc,
    input  logic [COMMIT_WIDTH*5-1:0]  cmt_rd,
    input  logic [COMMIT_WIDTH*XLEN-1:0] cmt_data,
    output logic                       cmt_ready,
    input  logic                       exp_valid,
    input  logic [XLEN-1:0]            exp_pc,
    input  logic [4:0]                 exp_rd,
    input  logic [XLEN-1:0]            exp_data,
    output logic                       exp_ready,
    input  logic                       halt,
    output logic                       mismatch,
    output logic [CNT_W-1:0]           err_count,
    output logic [CNT_W-1:0]           commit_count,
    output logic [XLEN-1:0]            first_err_pc,
    output logic                       done
);
    localparam int CB = $clog2(DEPTH) + 1;

    chk_state_t                       state;
    commit_entry_t [COMMIT_WIDTH-1:0] packed_lanes;
    commit_entry_t                    head;
    logic [COMMIT_WIDTH-1:0]          push_mask;
    logic [CB-1:0]                    count;
    logic                             pop, match;

    assign cmt_ready = state == CHK_RUN && (CB'(DEPTH) - count) >= CB'(COMMIT_WIDTH);
    assign exp_ready = (state == CHK_RUN || state == CHK_DRAIN) && count != '0 && exp_valid;
    assign pop       = exp_ready;
    assign done      = state == CHK_DONE;
    assign match     = head.pc == exp_pc &&
                       (exp_rd != 5'd0 ? head.rd == exp_rd && head.data == exp_data : head.rd == 5'd0);

    // Valid lanes are squeezed into consecutive slots in ascending lane order.
    always_comb begin
        packed_lanes = '0;
        push_mask    = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++)
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (cmt_valid[i] && ones_below(8'(cmt_valid), i) == k) begin
                    packed_lanes[k] = '{pc: cmt_pc[i*XLEN +: XLEN], rd: cmt_rd[i*5 +: 5],
                                        data: cmt_data[i*XLEN +: XLEN]};
                    push_mask[k]    = cmt_ready;
                end
    end

    commit_fifo #(.COMMIT_WIDTH(COMMIT_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push_mask(push_mask), .push_entry(packed_lanes),
        .pop(pop), .count(count), .head(head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CHK_RUN;
            mismatch     <= 1'b0;
            err_count    <= '0;
            commit_count <= '0;
            first_err_pc <= '0;
        end else begin
            mismatch <= pop && !match;
            if (pop) commit_count <= commit_count + CNT_W'(commit_count != '1);
            if (pop && !match) begin
                err_count <= err_count + CNT_W'(err_count != '1);
                if (err_count == '0) first_err_pc <= head.pc;
            end
            // Draining never pushes, so the queue empties exactly when the last entry pops.
            if (state == CHK_RUN && halt) state <= CHK_DRAIN;
            else if (state == CHK_DRAIN && count == CB'(pop)) state <= CHK_DONE;
`ifdef COMMIT_CHK_STOP_ON_ERR_EN
            if (pop && !match) state <= CHK_ERR;
`endif
        end
    end
endmodule

// File: tb/tb_commit_stream_checker.sv
// tb_commit_stream_checker: randomized and directed checks against a queue-based model.
`timescale 1ns/1ps
module tb_commit_stream_checker;
    localparam int CW = 4, DEPTH = 16, XLEN = 32, CNT_W = 32;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0, rst;
    logic [CW-1:0]      cmt_valid;
    logic [CW*XLEN-1:0] cmt_pc, cmt_data;
    logic [CW*5-1:0]    cmt_rd;
    logic cmt_ready, exp_valid, exp_ready, halt, mismatch, done;
    logic [XLEN-1:0]  exp_pc, exp_data, first_err_pc;
    logic [4:0]       exp_rd;
    logic [CNT_W-1:0] err_count, commit_count;

    logic [31:0] lpc [CW];
    logic [31:0] ldata [CW];
    logic [4:0]  lrd [CW];

    ent_t q[$];
    int m_state;
    logic [31:0] m_err, m_commit, m_first;
    logic m_mis;
    logic p_rdy, p_erdy, o_rdy, o_erdy;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        cmt_pc = '0;
        cmt_rd = '0;
        cmt_data = '0;
        for (int i = 0; i < CW; i++) begin
            cmt_pc[i*XLEN +: XLEN]   = lpc[i];
            cmt_rd[i*5 +: 5]         = lrd[i];
            cmt_data[i*XLEN +: XLEN] = ldata[i];
        end
    end

    commit_stream_checker #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_rd(cmt_rd),
        .cmt_data(cmt_data), .cmt_ready(cmt_ready), .exp_valid(exp_valid), .exp_pc(exp_pc),
        .exp_rd(exp_rd), .exp_data(exp_data), .exp_ready(exp_ready), .halt(halt),
        .mismatch(mismatch), .err_count(err_count), .commit_count(commit_count),
        .first_err_pc(first_err_pc), .done(done)
    );

    task automatic model_clear();
        q.delete();
        m_state = 0;
        m_err = 0;
        m_commit = 0;
        m_first = 0;
        m_mis = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmt_valid = '0;
        exp_valid = 1'b0;
        halt = 1'b0;
        model_clear();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_lanes(input logic rd_nonzero);
        for (int i = 0; i < CW; i++) begin
            lpc[i]   = $urandom & 32'hffff_fffc;
            lrd[i]   = rd_nonzero ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
            ldata[i] = $urandom;
        end
    endtask

    // Golden stream driven from the model queue head; corrupt bends the PC.
    task automatic feed(input logic corrupt);
        exp_valid = q.size() != 0;
        if (q.size() != 0) begin
            exp_pc   = q[0].pc ^ (corrupt ? 32'h4 : 32'h0);
            exp_rd   = q[0].rd;
            exp_data = q[0].data;
        end
    endtask

    // One clock: predict handshakes from the model, sample DUT, advance the model.
    task automatic step();
        ent_t f;
        logic ok, fail;
        int old;
        p_rdy  = m_state == 0 && (DEPTH - q.size() >= CW);
        p_erdy = (m_state == 0 || m_state == 1) && q.size() != 0 && exp_valid;
        #1;
        o_rdy  = cmt_ready;
        o_erdy = exp_ready;
        @(posedge clk);
        old = m_state;
        m_mis = 1'b0;
        fail = 1'b0;
        if (p_erdy) begin
            f = q.pop_front();
            ok = f.pc == exp_pc && (exp_rd != 0 ? (f.rd == exp_rd && f.data == exp_data) : f.rd == 0);
            if (m_commit != '1) m_commit++;
            if (!ok) begin
                fail = 1'b1;
                m_mis = 1'b1;
                if (m_err == 0) m_first = f.pc;
                if (m_err != '1) m_err++;
            end
        end
        if (p_rdy)
            for (int i = 0; i < CW; i++)
                if (cmt_valid[i]) q.push_back('{lpc[i], lrd[i], ldata[i]});
        if (old == 0 && halt) m_state = 1;
        else if (old == 1 && q.size() == 0) m_state = 2;
`ifdef COMMIT_CHK_STOP_ON_ERR_EN
        if (fail) m_state = 3;
`endif
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmt_valid = '0;
        exp_valid = 1'b0;
        halt = 1'b0;
        model_clear();
        #2;
        checks++; if (cmt_ready !== 1'b1) begin errors++; $display("FAIL reset_cmt_ready: got %b want 1", cmt_ready); end
        checks++; if (exp_ready !== 1'b0) begin errors++; $display("FAIL reset_exp_ready: got %b want 0", exp_ready); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (commit_count !== 0) begin errors++; $display("FAIL reset_commit_count: got %0d want 0", commit_count); end
        checks++; if (first_err_pc !== 0) begin errors++; $display("FAIL reset_first_err_pc: got %h want 0", first_err_pc); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_group();
        do_reset();
        rand_lanes(1'b1);
        for (int i = 0; i < CW; i++) lpc[i] = 32'h60 + 32'(4 * i);
        cmt_valid = 4'b1111;
        step();
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL full_group_accept: got %b want 1", o_rdy); end
        cmt_valid = '0;
        for (int i = 0; i < CW; i++) begin
            feed(1'b0);
            step();
            checks++; if (o_erdy !== 1'b1 || mismatch !== 1'b0)
                begin errors++; $display("FAIL full_group_drain%0d: exp_ready=%b mismatch=%b want 1/0", i, o_erdy, mismatch); end
        end
        exp_valid = 1'b0;
        checks++; if (commit_count !== 4) begin errors++; $display("FAIL full_group_commits: got %0d want 4", commit_count); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL full_group_errs: got %0d want 0", err_count); end
    endtask

    task automatic test_sparse();
        do_reset();
        rand_lanes(1'b1);
        lpc[0] = 32'hdead_0000;
        lpc[1] = 32'h60;
        lpc[2] = 32'hdead_0004;
        lpc[3] = 32'h64;
        cmt_valid = 4'b1010;
        step();
        cmt_valid = '0;
        exp_valid = 1'b1;
        exp_pc = 32'h60; exp_rd = lrd[1]; exp_data = ldata[1];
        step();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL sparse_first_0x60: mismatch=%b want 0", mismatch); end
        exp_pc = 32'h64; exp_rd = lrd[3]; exp_data = ldata[3];
        step();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL sparse_second_0x64: mismatch=%b want 0", mismatch); end
        exp_valid = 1'b0;
        checks++; if (commit_count !== 2 || err_count !== 0)
            begin errors++; $display("FAIL sparse_counts: commits=%0d errs=%0d want 2/0", commit_count, err_count); end
    endtask

    task automatic test_mismatch();
        do_reset();
        rand_lanes(1'b1);
        lpc[0] = 32'h7c; lrd[0] = 5'd0; ldata[0] = 32'h7;
        lpc[1] = 32'h80; lrd[1] = 5'd3; ldata[1] = 32'h7;
        cmt_valid = 4'b0011;
        step();
        cmt_valid = '0;
        exp_valid = 1'b1;
        exp_pc = 32'h7c; exp_rd = 5'd0; exp_data = 32'h5;
        step();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL rd0_data_ignored: mismatch=%b want 0", mismatch); end
        exp_pc = 32'h80; exp_rd = 5'd3; exp_data = 32'h5;
        step();
        exp_valid = 1'b0;
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL data_mismatch_pulse: mismatch=%b want 1", mismatch); end
        checks++; if (err_count !== 1) begin errors++; $display("FAIL data_mismatch_errs: got %0d want 1", err_count); end
        checks++; if (first_err_pc !== 32'h80) begin errors++; $display("FAIL first_err_pc: got %h want 80", first_err_pc); end
        step();
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mismatch_one_cycle: mismatch=%b want 0", mismatch); end
    endtask

    task automatic test_stop_on_err();
        logic [31:0] bad_pc;
        do_reset();
        rand_lanes(1'b1);
        bad_pc = lpc[0];
        cmt_valid = 4'b1111;
        step();
        feed(1'b1);
        step();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL stop_first_mismatch: mismatch=%b want 1", mismatch); end
        rand_lanes(1'b1);
        for (int i = 0; i < 3; i++) begin
            feed(1'b0);
            step();
        end
        cmt_valid = '0;
        exp_valid = 1'b0;
`ifdef COMMIT_CHK_STOP_ON_ERR_EN
        checks++; if (o_erdy !== 1'b0 || o_rdy !== 1'b0)
            begin errors++; $display("FAIL stop_frozen_ready: exp_ready=%b cmt_ready=%b want 0/0", o_erdy, o_rdy); end
        checks++; if (err_count !== 1 || commit_count !== 1 || done !== 1'b0)
            begin errors++; $display("FAIL stop_frozen_counts: errs=%0d commits=%0d done=%b want 1/1/0", err_count, commit_count, done); end
`else
        checks++; if (o_erdy !== 1'b1) begin errors++; $display("FAIL continue_exp_ready: got %b want 1", o_erdy); end
        checks++; if (err_count !== 1 || commit_count !== 4)
            begin errors++; $display("FAIL continue_counts: errs=%0d commits=%0d want 1/4", err_count, commit_count); end
`endif
        checks++; if (first_err_pc !== bad_pc) begin errors++; $display("FAIL stop_first_err_pc: got %h want %h", first_err_pc, bad_pc); end
    endtask

    task automatic test_full();
        int stalled;
        do_reset();
        cmt_valid = 4'b1111;
        for (int g = 0; g < 3; g++) begin
            rand_lanes(1'b0);
            step();
        end
        checks++; if (dut.u_fifo.count !== 12 || cmt_ready !== 1'b1)
            begin errors++; $display("FAIL full_12: count=%0d cmt_ready=%b want 12/1", dut.u_fifo.count, cmt_ready); end
        rand_lanes(1'b0);
        step();
        checks++; if (dut.u_fifo.count !== 16 || cmt_ready !== 1'b0)
            begin errors++; $display("FAIL full_16: count=%0d cmt_ready=%b want 16/0", dut.u_fifo.count, cmt_ready); end
        rand_lanes(1'b0);
        stalled = 0;
        for (int c = 0; c < 10; c++) begin
            feed(1'b0);
            step();
            checks++; if (o_rdy !== p_rdy) begin errors++; $display("FAIL full_ready_c%0d: got %b want %b", c, o_rdy, p_rdy); end
            if (o_rdy === 1'b1) break;
            stalled++;
        end
        checks++; if (stalled !== 4) begin errors++; $display("FAIL full_stall_cycles: got %0d want 4", stalled); end
        cmt_valid = '0;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            feed(1'b0);
            step();
        end
        exp_valid = 1'b0;
        checks++; if (commit_count !== 20 || err_count !== 0)
            begin errors++; $display("FAIL full_drain_counts: commits=%0d errs=%0d want 20/0", commit_count, err_count); end
    endtask

    task automatic test_halt();
        do_reset();
        rand_lanes(1'b1);
        cmt_valid = 4'b1111;
        step();
        rand_lanes(1'b1);
        cmt_valid = 4'b0001;
        halt = 1'b1;
        step();
        halt = 1'b0;
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL halt_cycle_accept: got %b want 1", o_rdy); end
        checks++; if (cmt_ready !== 1'b0 || dut.u_fifo.count !== 5)
            begin errors++; $display("FAIL halt_drain_entry: cmt_ready=%b count=%0d want 0/5", cmt_ready, dut.u_fifo.count); end
        cmt_valid = '0;
        for (int i = 0; i < 5; i++) begin
            feed(1'b0);
            halt = i == 1;
            step();
            checks++; if (done !== (i == 4)) begin errors++; $display("FAIL halt_done_%0d: got %b want %b", i, done, i == 4); end
        end
        halt = 1'b0;
        exp_valid = 1'b1;
        step();
        checks++; if (done !== 1'b1 || o_erdy !== 1'b0 || commit_count !== 5)
            begin errors++; $display("FAIL done_terminal: done=%b exp_ready=%b commits=%0d want 1/0/5", done, o_erdy, commit_count); end
        do_reset();
        rand_lanes(1'b1);
        cmt_valid = 4'b1111;
        halt = 1'b1;
        step();
        halt = 1'b0;
        cmt_valid = '0;
        feed(1'b0);
        step();
        feed(1'b0);
        step();
        rst = 1'b1;
        #1;
        checks++; if (dut.u_fifo.count !== 0 || done !== 1'b0 || commit_count !== 0 || err_count !== 0)
            begin errors++; $display("FAIL mid_drain_reset: count=%0d done=%b commits=%0d errs=%0d want 0", dut.u_fifo.count, done, commit_count, err_count); end
        exp_valid = 1'b0;
        model_clear();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic last_rdy;
        do_reset();
        last_rdy = 1'b1;
        cmt_valid = '0;
        for (int c = 0; c < 400; c++) begin
            if (last_rdy || cmt_valid == '0) begin
                rand_lanes(1'b0);
                cmt_valid = ($urandom_range(0, 9) < 3) ? '0 : CW'($urandom);
            end
            if ($urandom_range(0, 3) != 0) feed($urandom_range(0, 19) == 0);
            else exp_valid = 1'b0;
            halt = c == 350;
            step();
            last_rdy = o_rdy;
            checks++; if (o_rdy !== p_rdy || o_erdy !== p_erdy)
                begin errors++; $display("FAIL rand_ready_c%0d: cmt=%b exp=%b want %b/%b", c, o_rdy, o_erdy, p_rdy, p_erdy); end
            checks++; if (mismatch !== m_mis || err_count !== m_err || commit_count !== m_commit)
                begin errors++; $display("FAIL rand_state_c%0d: mis=%b errs=%0d commits=%0d want %b/%0d/%0d", c, mismatch, err_count, commit_count, m_mis, m_err, m_commit); end
            checks++; if (first_err_pc !== m_first || done !== (m_state == 2))
                begin errors++; $display("FAIL rand_capture_c%0d: first=%h done=%b want %h/%b", c, first_err_pc, done, m_first, m_state == 2); end
        end
        halt = 1'b0;
        cmt_valid = '0;
        exp_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < CW; i++) begin
            lpc[i] = '0;
            lrd[i] = '0;
            ldata[i] = '0;
        end
        exp_pc = '0;
        exp_rd = '0;
        exp_data = '0;
        test_reset();
        test_full_group();
        test_sparse();
        test_mismatch();
        test_stop_on_err();
        test_full();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
